// File: rtl/rcn_timer.sv
// rcn_timer: multi-channel down-counting timer, a slave on the 69-bit rcn ring.
//
// Ring slot semantics: the ring has no backpressure. Each cycle one slot enters
// on rcn_in and, one cycle later, the same slot leaves on rcn_out. It leaves
// unchanged unless it is a valid request that targets this block's 256-byte
// window. A targeted request is consumed and turned into a response in that
// same slot. A slot is "valid" when bit 68 is set; there is no ready signal.
//
// Ports:
//   clk      ring clock
//   rst_n    asynchronous active-low reset
//   rcn_in   ring input slot (69 bits)
//   rcn_out  ring output slot, registered (1-cycle latency)
//   req      one-cycle expiry pulse per channel (registered)
//   irq      level interrupt, OR over channels of STATUS & CTRL.irq_en
//
// Register map (byte offsets within the window):
//   0x00 PRESCALE[15:0]   0x04 STATUS (W1C)
//   0x10+0x10*i: +0 LOAD, +4 COUNT, +8 CTRL {irq_en, auto_reload, en}
module rcn_timer #(
    parameter logic [23:0] ADDR_BASE = 24'hFFFF00,
    parameter int          CHANNELS  = 4,
    parameter int          WIDTH     = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [68:0]         rcn_in,
    output logic [68:0]         rcn_out,
    output logic [CHANNELS-1:0] req,
    output logic                irq
);

    // Slot fields
    logic        slot_match;
    logic        slot_wr;
    logic [5:0]  word;      // addr[7:2]
    logic [3:0]  bmask;
    logic [31:0] wdata;

    assign slot_match = rcn_in[68] & rcn_in[67] & (rcn_in[55:40] == ADDR_BASE[23:8]);
    assign slot_wr    = rcn_in[66];
    assign word       = rcn_in[39:34];
    assign bmask      = rcn_in[59:56];
    assign wdata      = rcn_in[31:0];

    // Channel i occupies words 4+4i .. 4+4i+3, so word[5:2]-1 is the channel.
    logic [3:0] ch_sel;
    logic       ch_hit;
    assign ch_sel = word[5:2] - 4'd1;
    assign ch_hit = (word[5:2] != 4'd0) && (ch_sel < 4'(CHANNELS));

    // State
    logic [15:0]         prescale_q;
    logic [15:0]         pcnt_q;
    logic [CHANNELS-1:0] status_q;
    logic [WIDTH-1:0]    load_q  [CHANNELS];
    logic [WIDTH-1:0]    count_q [CHANNELS];
    logic [2:0]          ctrl_q  [CHANNELS];

    // Decode / datapath
    logic                tick;
    logic                wr_prescale;
    logic                wr_status;
    logic [CHANNELS-1:0] wr_load;
    logic [CHANNELS-1:0] wr_count;
    logic [CHANNELS-1:0] wr_ctrl;
    logic [CHANNELS-1:0] expire;
    logic [CHANNELS-1:0] irq_en;
    logic [CHANNELS-1:0] status_clr;
    logic [31:0]         rdata;

    // Merge write data into a WIDTH-bit register, one byte lane per mask bit.
    function automatic logic [WIDTH-1:0] merge_w(input logic [WIDTH-1:0] old,
                                                 input logic [31:0]      d,
                                                 input logic [3:0]       m);
        logic [WIDTH-1:0] r;
        for (int b = 0; b < WIDTH; b++) begin
            r[b] = m[b/8] ? d[b] : old[b];
        end
        return r;
    endfunction

    always_comb begin
        tick        = (pcnt_q == prescale_q);
        wr_prescale = slot_match && slot_wr && (word == 6'd0);
        wr_status   = slot_match && slot_wr && (word == 6'd1);
        wr_load     = '0;
        wr_count    = '0;
        wr_ctrl     = '0;
        expire      = '0;
        irq_en      = '0;
        rdata       = '0;

        case (word)
            6'd0:    rdata = {16'd0, prescale_q};
            6'd1:    rdata = 32'(status_q);
            default: ;
        endcase

        for (int i = 0; i < CHANNELS; i++) begin
            if (ch_hit && (ch_sel == 4'(i))) begin
                case (word[1:0])
                    2'd0: begin
                        rdata      = 32'(load_q[i]);
                        wr_load[i] = slot_match && slot_wr;
                    end
                    2'd1: begin
                        rdata       = 32'(count_q[i]);
                        wr_count[i] = slot_match && slot_wr;
                    end
                    2'd2: begin
                        rdata      = {29'd0, ctrl_q[i]};
                        wr_ctrl[i] = slot_match && slot_wr;
                    end
                    default: ;
                endcase
            end
            // A bus write to COUNT pre-empts the tick: no decrement, no expiry.
            expire[i] = tick && ctrl_q[i][0] && (count_q[i] == WIDTH'(1)) && !wr_count[i];
            irq_en[i] = ctrl_q[i][2];
        end
    end

    assign status_clr = (wr_status && bmask[0]) ? wdata[CHANNELS-1:0] : '0;
    assign irq        = |(status_q & irq_en);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rcn_out    <= '0;
            req        <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            status_q   <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                load_q[i]  <= '0;
                count_q[i] <= '0;
                ctrl_q[i]  <= '0;
            end
        end else begin
            rcn_out <= slot_match ? {1'b1, 1'b0, rcn_in[66:32], (slot_wr ? wdata : rdata)}
                                  : rcn_in;
            req     <= expire;

            if (wr_prescale) begin
                prescale_q <= {bmask[1] ? wdata[15:8] : prescale_q[15:8],
                               bmask[0] ? wdata[7:0]  : prescale_q[7:0]};
                pcnt_q     <= '0;
            end else if (tick) begin
                pcnt_q <= '0;
            end else begin
                pcnt_q <= pcnt_q + 16'd1;
            end

            // Expiry set has priority over a same-cycle W1C.
            status_q <= (status_q & ~status_clr) | expire;

            for (int i = 0; i < CHANNELS; i++) begin
                if (wr_load[i]) begin
                    load_q[i] <= merge_w(load_q[i], wdata, bmask);
                end

                if (wr_count[i]) begin
                    count_q[i] <= merge_w(count_q[i], wdata, bmask);
                end else if (tick && ctrl_q[i][0] && (count_q[i] != '0)) begin
                    if (count_q[i] == WIDTH'(1)) begin
                        count_q[i] <= ctrl_q[i][1] ? load_q[i] : '0;
                    end else begin
                        count_q[i] <= count_q[i] - WIDTH'(1);
                    end
                end

                // A bus write to CTRL overrides the one-shot en clear.
                if (wr_ctrl[i]) begin
                    if (bmask[0]) begin
                        ctrl_q[i] <= wdata[2:0];
                    end
                end else if (expire[i] && !ctrl_q[i][1]) begin
                    ctrl_q[i][0] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_rcn_timer.sv
// Testbench for rcn_timer: randomized and directed ring traffic, checked each
// cycle against a register-level reference model of the timer.
module tb_rcn_timer;

    localparam int          CHANNELS  = 4;
    localparam int          WIDTH     = 32;
    localparam logic [23:0] ADDR_BASE = 24'hFFFF00;
    localparam int unsigned WMASK     = (WIDTH == 32) ? 32'hFFFF_FFFF : ((32'd1 << WIDTH) - 1);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic [68:0]         rcn_in = '0;
    logic [68:0]         rcn_out;
    logic [CHANNELS-1:0] req;
    logic                irq;

    int n_tests = 0;
    int n_fail  = 0;

    rcn_timer #(.ADDR_BASE(ADDR_BASE), .CHANNELS(CHANNELS), .WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rcn_in  (rcn_in),
        .rcn_out (rcn_out),
        .req     (req),
        .irq     (irq)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [68:0] act, input logic [68:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int unsigned m_prescale, m_pcnt, m_status;
    int unsigned m_load  [CHANNELS];
    int unsigned m_count [CHANNELS];
    int unsigned m_ctrl  [CHANNELS];

    task automatic m_reset();
        m_prescale = 0;
        m_pcnt     = 0;
        m_status   = 0;
        for (int c = 0; c < CHANNELS; c++) begin
            m_load[c]  = 0;
            m_count[c] = 0;
            m_ctrl[c]  = 0;
        end
    endtask

    function automatic int unsigned wmask(input int unsigned old, input logic [31:0] d,
                                          input logic [3:0] m, input int unsigned keep);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = d[8*b +: 8];
        return r & keep;
    endfunction

    function automatic logic [31:0] m_read(input int off);
        int ch, sub;
        if (off == 0) return m_prescale;
        if (off == 4) return m_status;
        if (off >= 16) begin
            ch  = off / 16 - 1;
            sub = off % 16;
            if (ch < CHANNELS) begin
                if (sub == 0) return m_load[ch];
                if (sub == 4) return m_count[ch];
                if (sub == 8) return m_ctrl[ch];
            end
        end
        return 0;
    endfunction

    // Advance the model by one clock with slot s presented; return the
    // expected ring output, req vector and irq after the edge.
    task automatic m_step(input logic [68:0] s, output logic [68:0] eo,
                          output logic [CHANNELS-1:0] er, output logic ei);
        bit          match, wr, tick, wl, wc, wt;
        int          off, base;
        logic [3:0]  m;
        logic [31:0] d;
        int unsigned clr, new_status, n_count, n_ctrl;
        match = s[68] && s[67] && (s[55:40] == ADDR_BASE[23:8]);
        wr    = s[66];
        off   = int'(s[39:34]) * 4;
        m     = s[59:56];
        d     = s[31:0];
        eo    = match ? {2'b10, s[66:32], (wr ? d : m_read(off))} : s;
        tick  = (m_pcnt == m_prescale);
        er    = '0;
        clr   = 0;
        if (match && wr && off == 4 && m[0]) clr = d[7:0];
        new_status = m_status & ~clr;
        for (int c = 0; c < CHANNELS; c++) begin
            base    = 16 + 16 * c;
            wl      = match && wr && (off == base);
            wc      = match && wr && (off == base + 4);
            wt      = match && wr && (off == base + 8);
            n_count = m_count[c];
            n_ctrl  = m_ctrl[c];
            if (tick && ((m_ctrl[c] & 1) != 0) && !wc) begin
                if (m_count[c] > 1) begin
                    n_count = m_count[c] - 1;
                end else if (m_count[c] == 1) begin
                    er[c]      = 1'b1;
                    new_status = new_status | (1 << c);
                    if ((m_ctrl[c] & 2) != 0) begin
                        n_count = m_load[c];
                    end else begin
                        n_count = 0;
                        n_ctrl  = m_ctrl[c] & ~32'd1;
                    end
                end
            end
            if (wc) n_count = wmask(m_count[c], d, m, WMASK);
            if (wt) n_ctrl = wmask(m_ctrl[c], d, m, 7);
            if (wl) m_load[c] = wmask(m_load[c], d, m, WMASK);
            m_count[c] = n_count;
            m_ctrl[c]  = n_ctrl;
        end
        if (match && wr && off == 0) begin
            m_prescale = wmask(m_prescale, d, m, 32'hFFFF);
            m_pcnt     = 0;
        end else if (tick) begin
            m_pcnt = 0;
        end else begin
            m_pcnt = m_pcnt + 1;
        end
        m_status = new_status;
        ei = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (((m_status >> c) & 1) != 0 && (m_ctrl[c] & 4) != 0) ei = 1'b1;
        end
    endtask

    // ---------------- driver tasks ----------------
    function automatic logic [68:0] mk(input bit wr, input int off, input logic [3:0] m,
                                       input logic [31:0] d);
        logic [7:0] o;
        logic [5:0] id;
        logic [1:0] sq;
        o  = 8'(off);
        id = 6'($urandom);
        sq = 2'($urandom);
        return {1'b1, 1'b1, wr, id, m, ADDR_BASE[23:8], o[7:2], sq, d};
    endfunction

    task automatic cycle(input logic [68:0] s);
        logic [68:0]         eo;
        logic [CHANNELS-1:0] er;
        logic                ei;
        rcn_in = s;
        m_step(s, eo, er, ei);
        @(posedge clk);
        #1;
        check("rcn_out", rcn_out, eo);
        check("req", 69'(req), 69'(er));
        check("irq", 69'(irq), 69'(ei));
    endtask

    task automatic wr_reg(input int off, input logic [31:0] d, input logic [3:0] m = 4'hF);
        cycle(mk(1'b1, off, m, d));
    endtask

    task automatic rd_reg(input int off, output logic [31:0] v);
        cycle(mk(1'b0, off, 4'hF, $urandom));
        v = rcn_out[31:0];
    endtask

    // ---------------- stimulus ----------------
    logic [31:0] v;
    logic [68:0] s;
    int          n, last, npulse, off;
    logic [31:0] d;
    logic [3:0]  m;

    initial begin
        m_reset();
        rst_n  = 1'b0;
        rcn_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_rcn_out", rcn_out, 69'd0);
        check("reset_req", 69'(req), 69'd0);
        check("reset_irq", 69'(irq), 69'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reads after reset
        rd_reg(8'h00, v); check("rd_prescale_rst", 69'(v), 69'd0);
        rd_reg(8'h04, v); check("rd_status_rst", 69'(v), 69'd0);
        rd_reg(8'h10, v); check("rd_load0_rst", 69'(v), 69'd0);
        rd_reg(8'h14, v); check("rd_count0_rst", 69'(v), 69'd0);
        rd_reg(8'h18, v); check("rd_ctrl0_rst", 69'(v), 69'd0);

        // Pass-through: foreign request and a response slot
        s = {1'b1, 1'b1, 1'b0, 6'h05, 4'hF, 16'h0010, 6'h00, 2'b01, 32'hCAFEF00D};
        cycle(s);
        check("pass_foreign", rcn_out, s);
        s = {1'b1, 1'b0, 1'b1, 6'h2A, 4'h3, ADDR_BASE[23:8], 6'h04, 2'b10, 32'h0BADBEEF};
        cycle(s);
        check("pass_response", rcn_out, s);

        // Auto-reload, period 3
        wr_reg(8'h00, 0);
        wr_reg(8'h10, 3);
        wr_reg(8'h14, 3);
        wr_reg(8'h18, 3);
        last   = -1;
        npulse = 0;
        for (int k = 0; k < 15; k++) begin
            cycle('0);
            if (req[0]) begin
                if (last >= 0) check("req0_period", 69'(k - last), 69'd3);
                last = k;
                npulse++;
            end
            check("irq_off_no_en", 69'(irq), 69'd0);
        end
        check("req0_pulses", 69'(npulse), 69'd5);
        wr_reg(8'h18, 0);
        rd_reg(8'h04, v); check("status_set", 69'(v), 69'd1);
        wr_reg(8'h04, 1);
        rd_reg(8'h04, v); check("status_w1c", 69'(v), 69'd0);

        // One-shot with prescale 4
        wr_reg(8'h00, 4);
        n = 0;
        wr_reg(8'h24, 2); n = 1;
        wr_reg(8'h28, 5); n = 2;
        while (req[1] !== 1'b1 && n < 30) begin
            cycle('0);
            n++;
        end
        check("ch1_expiry_cycles", 69'(n), 69'd10);
        check("ch1_irq", 69'(irq), 69'd1);
        rd_reg(8'h24, v); check("ch1_count_zero", 69'(v), 69'd0);
        rd_reg(8'h28, v); check("ch1_ctrl_en_clr", 69'(v), 69'd4);
        npulse = 0;
        for (int k = 0; k < 20; k++) begin
            cycle('0);
            if (req[1]) npulse++;
        end
        check("ch1_no_more_req", 69'(npulse), 69'd0);

        // Byte mask and unmapped offsets
        wr_reg(8'h30, 32'h12345678, 4'b0011);
        rd_reg(8'h30, v); check("load2_bytemask", 69'(v), 69'h5678);
        wr_reg(8'h90, 32'hDEADBEEF);
        rd_reg(8'h90, v); check("unmapped_ch8", 69'(v), 69'd0);
        rd_reg(8'h1C, v); check("unmapped_1c", 69'(v), 69'd0);

        // W1C colliding with an expiry of channel 3
        wr_reg(8'h00, 0);
        wr_reg(8'h44, 3);
        wr_reg(8'h48, 1);
        cycle('0);
        cycle('0);
        wr_reg(8'h04, 8);
        check("w1c_expiry_req3", 69'(req[3]), 69'd1);
        rd_reg(8'h04, v); check("w1c_collision_status3", 69'(v[3]), 69'd1);

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            n = $urandom_range(0, 9);
            if (n < 4) begin
                cycle('0);
            end else if (n < 5) begin
                cycle(69'({$urandom, $urandom, $urandom}));
            end else begin
                off = $urandom_range(0, 63) * 4;
                d   = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 6));
                m   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
                cycle(mk(1'($urandom_range(0, 1)), off, m, d));
            end
        end

        // Reset mid-count with ch0 active at COUNT=5
        wr_reg(8'h00, 32'hFFFF);
        wr_reg(8'h14, 5);
        wr_reg(8'h18, 5);
        rcn_in = '0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rcn_out", rcn_out, 69'd0);
        check("midrst_req", 69'(req), 69'd0);
        check("midrst_irq", 69'(irq), 69'd0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) cycle('0);
        rd_reg(8'h00, v); check("midrst_prescale", 69'(v), 69'd0);
        rd_reg(8'h04, v); check("midrst_status", 69'(v), 69'd0);
        for (int c = 0; c < CHANNELS; c++) begin
            rd_reg(16 + 16 * c, v); check("midrst_load", 69'(v), 69'd0);
            rd_reg(20 + 16 * c, v); check("midrst_count", 69'(v), 69'd0);
            rd_reg(24 + 16 * c, v); check("midrst_ctrl", 69'(v), 69'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
